// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps at most one instruction-memory request in flight,
// and hands the returned word to decode with a valid/ready handshake.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned INST_WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic                  imem_gnt_i,
   input  logic                  imem_rvalid_i,
   input  logic [INST_WIDTH-1:0] imem_rdata_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [INST_WIDTH-1:0] inst_o,
   output logic [6:0]            opcode_o,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic                  misaligned_o
);

   localparam int unsigned OPCODE_W = 7;
   localparam logic [INST_WIDTH-1:0] NOP     = INST_WIDTH'(32'h0000_0013);
   localparam logic [OPCODE_W-1:0]   OP_ALUI = 7'b0010011;
   localparam logic [ADDR_WIDTH-1:0] PC_RST  = ADDR_WIDTH'(RESET_PC);
   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_REQUEST   = 2'd1,
      S_WAIT_RESP = 2'd2,
      S_HOLD      = 2'd3
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_pc;
   logic                  r_drop;
   logic                  r_req;
   logic                  r_valid;
   logic [INST_WIDTH-1:0] r_inst;
   logic [OPCODE_W-1:0]   r_opcode;
   logic [ADDR_WIDTH-1:0] r_pc_out;
   logic                  r_mis;

   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_pc_nxt;
   logic                  w_drop_nxt;
   logic                  w_valid_nxt;
   logic                  w_capture;

   assign imem_req_o   = r_req;
   assign imem_addr_o  = r_pc;
   assign valid_o      = r_valid;
   assign inst_o       = r_inst;
   assign opcode_o     = r_opcode;
   assign pc_o         = r_pc_out;
   assign misaligned_o = r_mis;

   // Next-state and datapath control; a redirect overrides every state.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_drop_nxt  = r_drop;
      w_valid_nxt = r_valid;
      w_capture   = 1'b0;
      if (redirect_i) begin
         w_pc_nxt    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
         w_valid_nxt = 1'b0;
         w_state_nxt = S_REQUEST;
         if ((r_state == S_REQUEST) && imem_gnt_i) begin
            // request just left: its response must be drained before refetching
            w_drop_nxt  = 1'b1;
            w_state_nxt = S_WAIT_RESP;
         end else if ((r_state == S_WAIT_RESP) && !imem_rvalid_i) begin
            w_drop_nxt  = 1'b1;
            w_state_nxt = S_WAIT_RESP;
         end else if (r_state == S_WAIT_RESP) begin
            // response arrives with the redirect: discard it right here
            w_drop_nxt = 1'b0;
         end
      end else begin
         case (r_state)
            S_IDLE: w_state_nxt = S_REQUEST;
            S_REQUEST: begin
               if (imem_gnt_i) w_state_nxt = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
               if (imem_rvalid_i) begin
                  if (r_drop) begin
                     w_drop_nxt  = 1'b0;
                     w_state_nxt = S_REQUEST;
                  end else begin
                     w_capture   = 1'b1;
                     w_valid_nxt = 1'b1;
                     w_pc_nxt    = r_pc + PC_STEP;
                     w_state_nxt = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (ready_i) begin
                  w_valid_nxt = 1'b0;
                  w_state_nxt = S_REQUEST;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // PC, drop flag, request strobe and the decode-facing output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pc     <= PC_RST;
         r_drop   <= 1'b0;
         r_req    <= 1'b0;
         r_valid  <= 1'b0;
         r_inst   <= NOP;
         r_opcode <= OP_ALUI;
         r_pc_out <= PC_RST;
         r_mis    <= 1'b0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_drop  <= w_drop_nxt;
         r_req   <= (w_state_nxt == S_REQUEST);
         r_valid <= w_valid_nxt;
         r_mis   <= redirect_i & (|redirect_pc_i[1:0]);
         if (w_capture) begin
            r_inst   <= imem_rdata_i;
            r_opcode <= imem_rdata_i[OPCODE_W-1:0];
            r_pc_out <= r_pc;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by randomized memory,
// decode and redirect traffic, checked against a transaction-level fetch model.
module tb_instruction_fetch;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        ready_i = 1'b0;
   logic        valid_o;
   logic [31:0] inst_o;
   logic [6:0]  opcode_o;
   logic [31:0] pc_o;
   logic        misaligned_o;

   instruction_fetch #(
      .RESET_PC  (32'h0000_0000),
      .ADDR_WIDTH(32),
      .INST_WIDTH(32)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .ready_i      (ready_i),
      .valid_o      (valid_o),
      .inst_o       (inst_o),
      .opcode_o     (opcode_o),
      .pc_o         (pc_o),
      .misaligned_o (misaligned_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   // stimulus knobs: k_gnt/k_ready 0=never 1=always 2=random, k_delay<0 = random
   int          k_gnt = 1, k_ready = 1, k_delay = 0;
   bit          k_spur = 0, k_force = 0;
   logic [31:0] k_force_data = 32'hDEAD_BEEF;
   bit          drv_redirect = 0;
   logic [31:0] drv_target = '0;

   // reference model: next address to fetch/deliver, memory responder, last-cycle record
   logic [31:0] exp_pc = '0;
   bit          exp_mis = 0;
   bit          busy = 0;
   int          delay = 0;
   logic [31:0] m_addr = '0;
   bit          p_redirect = 0, p_hold = 0, p_stall = 0;
   logic [31:0] p_pc_o = '0, p_inst = '0, p_addr = '0;
   int          accepts = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h0050_0293 ^ (a * 32'h0100_0193);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle();
      logic [31:0] want;
      bit          g;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
      if (busy && delay == 0) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = k_force ? k_force_data : mem_word(m_addr);
      end else if (!busy && k_spur && $urandom_range(0, 7) == 0) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = 32'hDEAD_BEEF;
      end
      case (k_gnt)
         0:       g = 1'b0;
         1:       g = 1'b1;
         default: g = ($urandom_range(0, 2) != 0);
      endcase
      imem_gnt_i    = imem_req_o && g;
      ready_i       = (k_ready == 2) ? 1'($urandom_range(0, 1)) : (k_ready == 1);
      redirect_i    = drv_redirect;
      redirect_pc_i = drv_target;
      #1;
      check("misaligned", misaligned_o, exp_mis);
      if (p_redirect) check("kill_valid", valid_o, 0);
      if (p_hold) begin
         check("hold_valid", valid_o, 1);
         check("hold_pc", pc_o, p_pc_o);
         check("hold_inst", inst_o, p_inst);
      end
      if (p_stall) begin
         check("stall_req", imem_req_o, 1);
         check("stall_addr", imem_addr_o, p_addr);
      end
      if (imem_req_o) begin
         check("one_outstanding", busy, 0);
         check("req_addr", imem_addr_o, exp_pc);
      end
      if (valid_o && ready_i && !redirect_i) begin
         want = mem_word(exp_pc);
         check("acc_pc", pc_o, exp_pc);
         check("acc_inst", inst_o, want);
         check("acc_opcode", opcode_o, want[6:0]);
         exp_pc = exp_pc + 32'd4;
         accepts++;
      end
      exp_mis = redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (redirect_i) exp_pc = redirect_pc_i & ~32'h3;
      p_redirect = redirect_i;
      p_hold     = valid_o && !ready_i && !redirect_i;
      p_pc_o     = pc_o;
      p_inst     = inst_o;
      p_stall    = imem_req_o && !imem_gnt_i && !redirect_i;
      p_addr     = imem_addr_o;
      if (imem_rvalid_i && busy) busy = 0;
      else if (busy)             delay--;
      if (imem_gnt_i) begin
         busy   = 1;
         m_addr = imem_addr_o;
         delay  = (k_delay < 0) ? int'($urandom_range(0, 2)) : k_delay;
      end
      drv_redirect = 0;
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   // Assert reset at a falling edge, check reset values, release two cycles later.
   task automatic do_reset(input bit late_rvalid);
      rst_ni        = 1'b0;
      imem_gnt_i    = 1'b0;
      redirect_i    = 1'b0;
      ready_i       = 1'b0;
      imem_rvalid_i = late_rvalid;
      imem_rdata_i  = 32'hDEAD_BEEF;
      #1;
      check("rst_req", imem_req_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_inst", inst_o, 32'h0000_0013);
      check("rst_opcode", opcode_o, 7'b0010011);
      check("rst_pc", pc_o, 32'h0);
      check("rst_addr", imem_addr_o, 32'h0);
      check("rst_mis", misaligned_o, 0);
      @(posedge clk_i);
      @(negedge clk_i);
      imem_rvalid_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni     = 1'b1;
      exp_pc     = 32'h0;
      exp_mis    = 0;
      busy       = 0;
      delay      = 0;
      p_redirect = 0;
      p_hold     = 0;
      p_stall    = 0;
   endtask

   initial begin
      @(negedge clk_i);
      do_reset(1'b0);

      // reset release, first fetch and accept
      k_gnt = 1; k_delay = 0; k_ready = 1;
      cycle();
      check("t1_req", imem_req_o, 1);
      check("t1_addr", imem_addr_o, 32'h0);
      cycle();
      cycle();
      check("t1_valid", valid_o, 1);
      check("t1_inst", inst_o, 32'h0050_0293);
      check("t1_opcode", opcode_o, 7'b0010011);
      check("t1_pc", pc_o, 32'h0);
      cycle();
      check("t1_next_req", imem_req_o, 1);
      check("t1_next_addr", imem_addr_o, 32'h4);

      // decode stalls for five cycles
      k_ready = 0;
      cycle();
      cycle();
      check("t2_valid", valid_o, 1);
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("t2_req_low", imem_req_o, 0);
      end
      k_ready = 1;
      cycle();
      check("t2_next_addr", imem_addr_o, 32'h8);
      check("t2_next_req", imem_req_o, 1);

      // redirect in HOLD kills the held word even with ready_i high
      k_ready = 0;
      cycle();
      cycle();
      k_ready = 1; drv_redirect = 1; drv_target = 32'h0000_0100;
      cycle();
      check("t3_valid", valid_o, 0);
      check("t3_req", imem_req_o, 1);
      check("t3_addr", imem_addr_o, 32'h100);

      // redirect while waiting: stale response drained, never presented
      k_delay = 2;
      cycle();
      k_force = 1; drv_redirect = 1; drv_target = 32'h0000_0200;
      cycle();
      check("t4_drain_req", imem_req_o, 0);
      cycle();
      check("t4_drain_req2", imem_req_o, 0);
      cycle();
      k_force = 0; k_delay = 0;
      check("t4_req", imem_req_o, 1);
      check("t4_addr", imem_addr_o, 32'h200);
      check("t4_no_valid", valid_o, 0);
      cycle();
      cycle();
      check("t4_valid", valid_o, 1);
      check("t4_inst", inst_o, mem_word(32'h200));
      cycle();

      // misaligned redirect target
      k_gnt = 0; drv_redirect = 1; drv_target = 32'h0000_0102;
      cycle();
      check("t5_mis_pulse", misaligned_o, 1);
      check("t5_addr", imem_addr_o, 32'h100);
      cycle();
      check("t5_mis_end", misaligned_o, 0);

      // PC wrap, then reset in the middle of a response wait
      drv_redirect = 1; drv_target = 32'hFFFF_FFFC;
      cycle();
      check("t6_top_addr", imem_addr_o, 32'hFFFF_FFFC);
      k_gnt = 1;
      cycle();
      cycle();
      check("t6_top_pc", pc_o, 32'hFFFF_FFFC);
      cycle();
      check("t6_wrap_req", imem_req_o, 1);
      check("t6_wrap_addr", imem_addr_o, 32'h0);
      k_delay = 1;
      cycle();
      do_reset(1'b1);
      k_delay = 0;
      cycle();
      check("t6_after_req", imem_req_o, 1);
      check("t6_after_addr", imem_addr_o, 32'h0);
      check("t6_after_valid", valid_o, 0);

      // randomized traffic
      k_gnt = 2; k_ready = 2; k_delay = -1; k_spur = 1;
      accepts = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) do_reset(1'($urandom_range(0, 1)));
         if ($urandom_range(0, 15) == 0) begin
            drv_redirect = 1;
            case ($urandom_range(0, 3))
               0:       drv_target = $urandom;
               1:       drv_target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
               2:       drv_target = 32'($urandom_range(0, 255));
               default: drv_target = $urandom & ~32'h3;
            endcase
         end
         cycle();
      end
      check("progress", accepts > 100, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
